zt_mem_1r1w_vbnk: RTL and testbench
===================================

Name: zt_mem_1r1w_vbnk

Overview:
- Memory-side responder for the t1 bank interface used by the cuckoo hash designs. It receives t1_writeA / t1_readB from the table controller and returns t1_doutB.
- Provides NUMVBNK independent banks, each NUMVROW x PHWIDTH, with one write port (A) and one read port (B) per bank.
- After reset it runs a self-clearing init sweep, and holds ready low until every row reads back zero.
- The read path has a configurable MEM_DELAY pipeline, so controller CRC/MEM delay alignment is exercised against real latency.

Parameters:
- NUMVBNK, 4, number of virtual banks.
- NUMVROW, 4, rows per bank; need not be a power of two.
- PHWIDTH, 7, physical row width in bits (1+KYWIDTH+DTWIDTH in the table).
- MEM_DELAY, 0, extra read pipeline stages; legal range 0..4.
- BITVROW, NUMVROW>1 ? $clog2(NUMVROW) : 1, row address width (derived).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- ready  output  1  high when the init sweep has finished and accesses are accepted.
- t1_writeA  input  NUMVBNK  per-bank write enable.
- t1_addrA  input  NUMVBNK*BITVROW  per-bank write row; bank b uses slice [b*BITVROW +: BITVROW].
- t1_dinA  input  NUMVBNK*PHWIDTH  per-bank write data.
- t1_readB  input  NUMVBNK  per-bank read enable.
- t1_addrB  input  NUMVBNK*BITVROW  per-bank read row.
- t1_doutB  output  NUMVBNK*PHWIDTH  per-bank read data.
- err  output  1  sticky error: access while not ready, or row address >= NUMVROW.

Behaviour:
- Reset (rst=0, async): the following take effect immediately and hold while rst=0.
  - ready=0, t1_doutB=0, err=0.
  - Read pipelines flushed.
  - init_row=0, FSM=INIT.
  - Array contents are don't-care until the sweep completes.
- FSM INIT:
  - On each edge with rst=1, row init_row of every bank is written to 0, then init_row increments.
  - On the edge that clears row NUMVROW-1, the FSM goes to RUN and ready is registered to 1.
  - ready is therefore high after exactly NUMVROW edges following reset release.
- FSM RUN: terminal state. Only reset leaves it.
- Write: on an edge with ready=1, t1_writeA[b]=1 and addrA_b<NUMVROW, bank b row addrA_b <= dinA_b.
- Read latency:
  - A read sampled at edge N (readB[b]=1, ready=1) drives doutB_b with the row contents from edge N+1+MEM_DELAY onward.
  - MEM_DELAY=0 gives 1-cycle registered latency.
- doutB_b holds the last completed read until the next read for bank b completes. Cycles without a read never alter it.
- Read/write collision (same bank, same row, same edge): the read returns the pre-write data (read-before-write). The write lands normally.
- Banks are fully independent. Simultaneous accesses to different banks never interact.
- Back-to-back reads, one per cycle per bank, are fully pipelined with no bubbles.
- Out-of-range row (addr >= NUMVROW):
  - Write is dropped.
  - Read completes with data 0 at the normal latency.
  - err <= 1.
- Access while ready=0 (any writeA or readB bit set during INIT):
  - The access is ignored, with no array change and no read completion.
  - The init sweep is unaffected.
  - err <= 1.
- err is cleared only by reset.
- Reset mid-operation:
  - In-flight reads are discarded and t1_doutB=0 immediately.
  - After release, the sweep restarts from row 0 and all contents read 0 once ready is high.
- Width rules: address slices are treated as unsigned. The init_row counter is BITVROW bits wide plus enough headroom to never wrap before NUMVROW-1.

Test Plan:
- Release rst, NUMVROW=4 -> ready=0 for 3 edges and 1 after the 4th edge. Then read rows 0..3 of all banks -> t1_doutB=0, err=0.
- MEM_DELAY=2, write bank1 row2 = 7'h5A, then read bank1 row2 at edge N -> doutB_1=7'h5A from edge N+3; prior value held at edges N+1 and N+2.
- Same edge: write bank0 row1 = 7'h11 over old 7'h22, and read bank0 row1 -> read returns 7'h22. A following read returns 7'h11.
- NUMVROW=3, write bank2 row3 = 7'h7F, then read bank2 row3 -> write dropped, read data 0, err=1 and stays 1. Row 0..2 contents unchanged.
- Assert readB[3] during INIT -> no doutB change, err=1, and ready still rises on schedule.
- Pulse rst low while reads are in flight with MEM_DELAY=3 -> doutB=0 immediately. After release, the sweep restarts and the previously written row reads 0.

Source files
------------

// File: rtl/zt_mem_1r1w_vbnk.sv
// Banked 1R1W memory responder for the t1 table interface: self-clearing init sweep,
// read-before-write collisions and a MEM_DELAY-deep read pipeline in front of t1_doutB.
module zt_mem_1r1w_vbnk #(
    parameter int unsigned NUMVBNK   = 4,
    parameter int unsigned NUMVROW   = 4,
    parameter int unsigned PHWIDTH   = 7,
    parameter int unsigned MEM_DELAY = 0,
    parameter int unsigned BITVROW   = (NUMVROW > 1) ? $clog2(NUMVROW) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         ready,
    input  logic [NUMVBNK-1:0]           t1_writeA,
    input  logic [NUMVBNK*BITVROW-1:0]   t1_addrA,
    input  logic [NUMVBNK*PHWIDTH-1:0]   t1_dinA,
    input  logic [NUMVBNK-1:0]           t1_readB,
    input  logic [NUMVBNK*BITVROW-1:0]   t1_addrB,
    output logic [NUMVBNK*PHWIDTH-1:0]   t1_doutB,
    output logic                         err
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                       state_q, state_d;
    logic [BITVROW:0]             init_row;
    logic                         init_last;
    logic [PHWIDTH-1:0]           mem [NUMVBNK][NUMVROW];
    logic [NUMVBNK-1:0]           a_oor, b_oor, wr_ok, rd_ok;
    logic [NUMVBNK*PHWIDTH-1:0]   rd_word;
    logic                         err_set;
    logic [NUMVBNK-1:0]           pv [MEM_DELAY+1];
    logic [NUMVBNK*PHWIDTH-1:0]   pd [MEM_DELAY+1];

    always_comb begin
        a_oor   = '0;
        b_oor   = '0;
        wr_ok   = '0;
        rd_ok   = '0;
        rd_word = '0;
        for (int unsigned b = 0; b < NUMVBNK; b++) begin
            a_oor[b] = 32'(t1_addrA[b*BITVROW +: BITVROW]) >= NUMVROW;
            b_oor[b] = 32'(t1_addrB[b*BITVROW +: BITVROW]) >= NUMVROW;
            wr_ok[b] = ready && t1_writeA[b] && !a_oor[b];
            rd_ok[b] = ready && t1_readB[b];
            // Out-of-range reads still complete, carrying zero data.
            if (!b_oor[b])
                rd_word[b*PHWIDTH +: PHWIDTH] = mem[b][t1_addrB[b*BITVROW +: BITVROW]];
        end
        err_set = ready ? |((t1_writeA & a_oor) | (t1_readB & b_oor))
                        : |(t1_writeA | t1_readB);
    end

    always_comb begin
        state_d   = state_q;
        init_last = 32'(init_row) == NUMVROW - 1;
        if (state_q == ST_INIT && init_last)
            state_d = ST_RUN;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_INIT;
            init_row <= '0;
            ready    <= 1'b0;
            err      <= 1'b0;
        end else begin
            state_q <= state_d;
            ready   <= (state_d == ST_RUN);
            if (state_q == ST_INIT && !init_last)
                init_row <= init_row + 1'b1;
            if (err_set)
                err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned b = 0; b < NUMVBNK; b++) begin
            if (state_q == ST_INIT)
                mem[b][init_row[BITVROW-1:0]] <= '0;
            else if (wr_ok[b])
                mem[b][t1_addrA[b*BITVROW +: BITVROW]] <= t1_dinA[b*PHWIDTH +: PHWIDTH];
        end
    end

    // Stage 0 captures array data on the sampling edge, so a same-edge write is not seen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i <= MEM_DELAY; i++) begin
                pv[i] <= '0;
                pd[i] <= '0;
            end
            t1_doutB <= '0;
        end else begin
            pv[0] <= rd_ok;
            pd[0] <= rd_word;
            for (int unsigned i = 1; i <= MEM_DELAY; i++) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
            end
            for (int unsigned b = 0; b < NUMVBNK; b++) begin
                if (pv[MEM_DELAY][b])
                    t1_doutB[b*PHWIDTH +: PHWIDTH] <= pd[MEM_DELAY][b*PHWIDTH +: PHWIDTH];
            end
        end
    end

endmodule

// File: tb/tb_zt_mem_1r1w_vbnk.sv
// Directed bench: instance 0 has 4 rows / no extra delay, instance 1 has 3 rows / MEM_DELAY=2.
module tb_zt_mem_1r1w_vbnk;

    logic        clk;
    logic        rst_n;
    logic [3:0]  we [2];
    logic [3:0]  re [2];
    logic [7:0]  aa [2];
    logic [7:0]  ab [2];
    logic [27:0] da [2];
    logic [27:0] db [2];
    logic        rdy [2];
    logic        er [2];

    int checks;
    int failures;

    logic [1:0] rows [5];
    logic [6:0] exb  [8];

    zt_mem_1r1w_vbnk #(.NUMVBNK(4), .NUMVROW(4), .PHWIDTH(7), .MEM_DELAY(0)) u_d0 (
        .clk(clk), .rst(rst_n), .ready(rdy[0]),
        .t1_writeA(we[0]), .t1_addrA(aa[0]), .t1_dinA(da[0]),
        .t1_readB(re[0]), .t1_addrB(ab[0]), .t1_doutB(db[0]), .err(er[0])
    );

    zt_mem_1r1w_vbnk #(.NUMVBNK(4), .NUMVROW(3), .PHWIDTH(7), .MEM_DELAY(2)) u_d2 (
        .clk(clk), .rst(rst_n), .ready(rdy[1]),
        .t1_writeA(we[1]), .t1_addrA(aa[1]), .t1_dinA(da[1]),
        .t1_readB(re[1]), .t1_addrB(ab[1]), .t1_doutB(db[1]), .err(er[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [27:0] pack(input logic [6:0] b3, input logic [6:0] b2,
                                         input logic [6:0] b1, input logic [6:0] b0);
        return {b3, b2, b1, b0};
    endfunction

    function automatic logic [7:0] pack_a(input logic [1:0] a3, input logic [1:0] a2,
                                          input logic [1:0] a1, input logic [1:0] a0);
        return {a3, a2, a1, a0};
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        rows = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
        exb  = '{7'h00, 7'h00, 7'h00, 7'h23, 7'h00, 7'h21, 7'h22, 7'h23};
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            we[i] = '0; re[i] = '0; aa[i] = '0; ab[i] = '0; da[i] = '0;
        end
        tick(); tick();
        chk("rst_rdy0", 32'(rdy[0]), 32'd0);
        chk("rst_dout0", 32'(db[0]), 32'd0);
        chk("rst_err0", 32'(er[0]), 32'd0);
        chk("rst_rdy1", 32'(rdy[1]), 32'd0);

        // Sweep length equals row count.
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("init_rdy0", 32'(rdy[0]), 32'(k >= 4));
            chk("init_rdy1", 32'(rdy[1]), 32'(k >= 3));
        end

        for (int r = 0; r < 4; r++) begin
            re[0] = 4'hF; ab[0] = {4{2'(r)}};
            re[1] = (r < 3) ? 4'hF : 4'h0; ab[1] = {4{2'(r)}};
            tick();
            chk("zero_dout0", 32'(db[0]), 32'd0);
            chk("zero_dout1", 32'(db[1]), 32'd0);
        end
        re[0] = '0; re[1] = '0;
        tick(); tick(); tick();
        chk("zero_tail0", 32'(db[0]), 32'd0);
        chk("zero_tail1", 32'(db[1]), 32'd0);
        chk("zero_err0", 32'(er[0]), 32'd0);
        chk("zero_err1", 32'(er[1]), 32'd0);

        // Instance 0: multi-bank write, collision, hold, independence, back-to-back.
        we[0] = 4'b1101; aa[0] = pack_a(2'd0, 2'd3, 2'd0, 2'd1);
        da[0] = pack(7'h44, 7'h33, 7'h00, 7'h22);
        tick();
        we[0] = 4'b0001; aa[0] = pack_a(2'd0, 2'd0, 2'd0, 2'd1);
        da[0] = pack(7'h00, 7'h00, 7'h00, 7'h11);
        re[0] = 4'b0001; ab[0] = pack_a(2'd0, 2'd0, 2'd0, 2'd1);
        tick();
        we[0] = '0; re[0] = '0;
        chk("coll_edge", 32'(db[0]), 32'd0);
        tick();
        chk("coll_rbw", 32'(db[0]), 32'(pack(7'h00, 7'h00, 7'h00, 7'h22)));
        re[0] = 4'b0001;
        tick();
        re[0] = '0;
        chk("coll_pre", 32'(db[0]), 32'(pack(7'h00, 7'h00, 7'h00, 7'h22)));
        tick();
        chk("coll_new", 32'(db[0]), 32'(pack(7'h00, 7'h00, 7'h00, 7'h11)));
        tick();
        chk("hold", 32'(db[0]), 32'(pack(7'h00, 7'h00, 7'h00, 7'h11)));
        re[0] = 4'b1110; ab[0] = pack_a(2'd0, 2'd3, 2'd1, 2'd0);
        tick();
        re[0] = '0;
        tick();
        chk("indep", 32'(db[0]), 32'(pack(7'h44, 7'h33, 7'h00, 7'h11)));
        re[0] = 4'b0100; ab[0] = pack_a(2'd0, 2'd0, 2'd0, 2'd0);
        tick();
        ab[0] = pack_a(2'd0, 2'd3, 2'd0, 2'd0);
        tick();
        re[0] = '0;
        chk("b2b_0", 32'(db[0]), 32'(pack(7'h44, 7'h00, 7'h00, 7'h11)));
        tick();
        chk("b2b_1", 32'(db[0]), 32'(pack(7'h44, 7'h33, 7'h00, 7'h11)));
        chk("run_err0", 32'(er[0]), 32'd0);

        // Instance 1: latency 3, out-of-range write/read.
        we[1] = 4'b0110; aa[1] = pack_a(2'd0, 2'd0, 2'd2, 2'd0);
        da[1] = pack(7'h00, 7'h21, 7'h5A, 7'h00);
        tick();
        we[1] = 4'b0100; aa[1] = pack_a(2'd0, 2'd1, 2'd0, 2'd0);
        da[1] = pack(7'h00, 7'h22, 7'h00, 7'h00);
        tick();
        aa[1] = pack_a(2'd0, 2'd2, 2'd0, 2'd0);
        da[1] = pack(7'h00, 7'h23, 7'h00, 7'h00);
        tick();
        we[1] = '0;
        re[1] = 4'b0010; ab[1] = pack_a(2'd0, 2'd0, 2'd2, 2'd0);
        tick();
        re[1] = '0;
        chk("lat_n0", 32'(db[1]), 32'd0);
        tick();
        chk("lat_n1", 32'(db[1]), 32'd0);
        tick();
        chk("lat_n2", 32'(db[1]), 32'd0);
        tick();
        chk("lat_n3", 32'(db[1]), 32'(pack(7'h00, 7'h00, 7'h5A, 7'h00)));
        chk("pre_oor_err1", 32'(er[1]), 32'd0);
        we[1] = 4'b0100; aa[1] = pack_a(2'd0, 2'd3, 2'd0, 2'd0);
        da[1] = pack(7'h00, 7'h7F, 7'h00, 7'h00);
        tick();
        we[1] = '0;
        chk("oor_err", 32'(er[1]), 32'd1);
        for (int i = 0; i < 8; i++) begin
            if (i < 5) begin
                re[1] = 4'b0100; ab[1] = pack_a(2'd0, rows[i], 2'd0, 2'd0);
            end else begin
                re[1] = '0;
            end
            tick();
            chk("oor_rd", 32'(db[1]), 32'(pack(7'h00, exb[i], 7'h5A, 7'h00)));
        end
        re[1] = '0;
        chk("oor_sticky", 32'(er[1]), 32'd1);

        // Reset with a read in flight on instance 1.
        re[1] = 4'b0010; ab[1] = pack_a(2'd0, 2'd0, 2'd2, 2'd0);
        tick();
        re[1] = '0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_dout1", 32'(db[1]), 32'd0);
        chk("mid_dout0", 32'(db[0]), 32'd0);
        chk("mid_err1", 32'(er[1]), 32'd0);
        chk("mid_rdy1", 32'(rdy[1]), 32'd0);
        tick(); tick();
        chk("mid_hold1", 32'(db[1]), 32'd0);
        rst_n = 1'b1;
        re[0] = 4'b1000; ab[0] = '0;
        tick();
        re[0] = '0;
        chk("init_acc_err0", 32'(er[0]), 32'd1);
        chk("init_acc_rdy0", 32'(rdy[0]), 32'd0);
        chk("init_flush1", 32'(db[1]), 32'd0);
        tick(); tick();
        chk("re_rdy1", 32'(rdy[1]), 32'd1);
        chk("re_rdy0_early", 32'(rdy[0]), 32'd0);
        tick();
        chk("re_rdy0", 32'(rdy[0]), 32'd1);
        chk("init_acc_dout0", 32'(db[0]), 32'd0);

        we[0] = 4'b0001; aa[0] = pack_a(2'd0, 2'd0, 2'd0, 2'd2);
        da[0] = pack(7'h00, 7'h00, 7'h00, 7'h3C);
        we[1] = 4'b0010; aa[1] = pack_a(2'd0, 2'd0, 2'd0, 2'd0);
        da[1] = pack(7'h00, 7'h00, 7'h0F, 7'h00);
        tick();
        we[0] = '0; we[1] = '0;
        re[0] = 4'b0001; ab[0] = pack_a(2'd0, 2'd0, 2'd0, 2'd2);
        re[1] = 4'b0010; ab[1] = pack_a(2'd0, 2'd0, 2'd0, 2'd0);
        tick();
        ab[0] = pack_a(2'd0, 2'd0, 2'd0, 2'd1);
        ab[1] = pack_a(2'd0, 2'd0, 2'd2, 2'd0);
        tick();
        re[0] = '0; re[1] = '0;
        chk("post_wr0", 32'(db[0]), 32'(pack(7'h00, 7'h00, 7'h00, 7'h3C)));
        tick();
        chk("post_clr0", 32'(db[0]), 32'd0);
        tick();
        chk("post_wr1", 32'(db[1]), 32'(pack(7'h00, 7'h00, 7'h0F, 7'h00)));
        tick();
        chk("post_clr1", 32'(db[1]), 32'd0);
        chk("post_err0", 32'(er[0]), 32'd1);
        chk("post_err1", 32'(er[1]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
